// File: rtl/jump_charge_ctrl.sv
// Push-button front end for the game fsm: synchronise, debounce, convert hold
// time into a saturating jump distance, lock out during animation, and turn a press after death into a restart pulse.
module jump_charge_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 2,
    parameter int MIN_DIST        = 4,
    parameter int MAX_DIST        = 60,
    parameter int COOLDOWN_CYCLES = 40,
    parameter int RESTART_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       dead,
    output logic [7:0] jump_dist,
    output logic       restart,
    output logic       charging,
    output logic       locked,
    output logic [7:0] last_dist
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam int RW = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHARGE    = 3'd1,
        COOLDOWN  = 3'd2,
        ARM       = 3'd3,
        DEAD_WAIT = 3'd4,
        RESTART   = 3'd5
    } state_t;

    state_t          state, state_nxt;
    logic            s_meta, s;
    logic            btn_db, btn_db_q;
    logic [DW-1:0]   dcnt;
    logic [TW-1:0]   tcnt, tcnt_nxt;
    logic [CW-1:0]   ccnt, ccnt_nxt;
    logic [RW-1:0]   rcnt, rcnt_nxt;
    logic [7:0]      jump_nxt, last_nxt;
    logic            rise, fall;

    // Input conditioning: two-flop synchroniser, then a level must hold for
    // DEBOUNCE_CYCLES consecutive samples before btn_db follows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta   <= 1'b0;
            s        <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            dcnt     <= '0;
        end else begin
            s_meta   <= btn;
            s        <= s_meta;
            btn_db_q <= btn_db;
            if (s == btn_db) begin
                dcnt <= '0;
            end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= s;
                dcnt   <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    assign rise = btn_db & ~btn_db_q;
    assign fall = ~btn_db & btn_db_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            jump_dist <= '0;
            last_dist <= '0;
            tcnt      <= '0;
            ccnt      <= '0;
            rcnt      <= '0;
        end else begin
            state     <= state_nxt;
            jump_dist <= jump_nxt;
            last_dist <= last_nxt;
            tcnt      <= tcnt_nxt;
            ccnt      <= ccnt_nxt;
            rcnt      <= rcnt_nxt;
        end
    end

    // Death takes precedence over every button event in the playable states.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dead)      state_nxt = DEAD_WAIT;
                else if (rise) state_nxt = CHARGE;
            end
            CHARGE: begin
                if (dead)      state_nxt = DEAD_WAIT;
                else if (fall) state_nxt = COOLDOWN;
            end
            COOLDOWN: begin
                if (dead)            state_nxt = DEAD_WAIT;
                else if (ccnt == '0) state_nxt = btn_db ? ARM : IDLE;
            end
            ARM: begin
                if (!btn_db) state_nxt = IDLE;
            end
            DEAD_WAIT: begin
                if (rise) state_nxt = RESTART;
            end
            RESTART: begin
                if (rcnt == '0) state_nxt = ARM;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        jump_nxt = '0;
        last_nxt = last_dist;
        tcnt_nxt = tcnt;
        ccnt_nxt = ccnt;
        rcnt_nxt = rcnt;
        case (state)
            IDLE: begin
                if (!dead && rise) begin
                    jump_nxt = 8'(MIN_DIST);
                    tcnt_nxt = '0;
                end
            end
            CHARGE: begin
                if (!dead && fall) begin
                    last_nxt = jump_dist;
                    ccnt_nxt = CW'(COOLDOWN_CYCLES - 1);
                end else if (!dead) begin
                    jump_nxt = jump_dist;
                    if (tcnt == TW'(TICK_DIV - 1)) begin
                        tcnt_nxt = '0;
                        if (jump_dist != 8'(MAX_DIST)) jump_nxt = jump_dist + 8'd1;
                    end else begin
                        tcnt_nxt = tcnt + 1'b1;
                    end
                end
            end
            COOLDOWN: begin
                if (ccnt != '0) ccnt_nxt = ccnt - 1'b1;
            end
            DEAD_WAIT: begin
                if (rise) rcnt_nxt = RW'(RESTART_CYCLES - 1);
            end
            RESTART: begin
                if (rcnt != '0) rcnt_nxt = rcnt - 1'b1;
            end
            default: ;
        endcase
    end

    // Status flags decode the registered state, so they line up with jump_dist.
    always_comb begin
        charging = (state == CHARGE);
        restart  = (state == RESTART);
        locked   = (state == COOLDOWN) || (state == DEAD_WAIT) ||
                   (state == RESTART)  || (state == ARM);
    end

endmodule

// File: doc/jump_charge_ctrl.md
# jump_charge_ctrl

Input sequencer in front of the game `fsm`. It turns one raw push-button into the `jump_dist` stream and the `restart` pulse that `fsm` consumes. The button is synchronised and debounced, and hold time is converted into a saturating charge value. After each jump the block locks out input for the shift animation. When `dead` is reported, it converts the next press into a restart. All outputs are registered and drive `fsm.jump_dist` and `fsm.restart` directly.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required before the debounced button changes.
- `TICK_DIV`, 2: CHARGE cycles per +1 charge step.
- `MIN_DIST`, 4: first charge value. Must be ≥1, because 0 means "no jump".
- `MAX_DIST`, 60: saturation value. Must be ≤255 and ≥`MIN_DIST`.
- `COOLDOWN_CYCLES`, 40: post-release lockout, long enough to cover the fsm shift/jump animation.
- `RESTART_CYCLES`, 2: width of the `restart` pulse.
- `clk`, in, 1: single clock, the game tick. Everything updates on posedge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `btn`, in, 1: raw asynchronous button, high = pressed.
- `dead`, in, 1: from `fsm.dead`.
- `jump_dist`, out, 8: charge value while charging, 0 otherwise.
- `restart`, out, 1: restart request to `fsm`.
- `charging`, out, 1: high in CHARGE.
- `locked`, out, 1: high in COOLDOWN, DEAD_WAIT, RESTART and ARM.
- `last_dist`, out, 8: final value of the most recent completed charge.

## Operation
- **Synchroniser:** 2-flop synchroniser `btn` → `s`.
- **Debounce counter `dcnt`:**
  - Cleared when `s == btn_db`.
  - Otherwise incremented.
  - When `dcnt == DEBOUNCE_CYCLES-1` and `s != btn_db`: `btn_db <= s`, `dcnt <= 0`.
- **Edge flags:** `rise = btn_db & ~btn_db_q`, `fall = ~btn_db & btn_db_q`.
- **States:**
  - **IDLE:** `jump_dist=0`. On `rise` → CHARGE, load `jump_dist=MIN_DIST`, clear `tcnt`.
  - **CHARGE:**
    - Each cycle `tcnt++`.
    - When `tcnt==TICK_DIV-1`: clear `tcnt`; `jump_dist++` unless already `MAX_DIST` (saturate, never wrap).
    - On `fall` → COOLDOWN: `last_dist <= jump_dist`, `jump_dist <= 0`, load `ccnt=COOLDOWN_CYCLES-1`.
  - **COOLDOWN:** `jump_dist=0`; button ignored. Decrement `ccnt`; at 0 → IDLE if `btn_db==0`, else → ARM.
  - **ARM:** wait for `btn_db==0`, then → IDLE. A held button never auto-starts a charge.
  - **DEAD_WAIT:** `jump_dist=0`. On `rise` → RESTART with `rcnt=RESTART_CYCLES-1`.
  - **RESTART:** `restart=1`; decrement `rcnt`; at 0 → ARM, with `restart` low from that cycle.
- **Priority:**
  - `dead==1` in IDLE, CHARGE or COOLDOWN → DEAD_WAIT next cycle, with `jump_dist <= 0`.
  - An in-progress charge is discarded: `last_dist` is not updated.
  - `dead` is ignored in RESTART and ARM, because `fsm` clears it during reset.
- **Simultaneous `fall` and `dead` in CHARGE:** `dead` wins.
- **Reset values** (async, `rst_n=0`): state IDLE; `jump_dist=0`, `restart=0`, `charging=0`, `locked=0`, `last_dist=0`; all counters 0; `btn_db=0`; synchroniser flops 0.
- **Reset mid-charge:** outputs return to 0 immediately and asynchronously; no partial jump is emitted.

## Timing
- **btn → `btn_db` latency:** 2 (sync) + `DEBOUNCE_CYCLES` cycles of stable level. Glitches shorter than `DEBOUNCE_CYCLES` cycles are invisible.
- **`btn_db` edge → state/output change:** +1 cycle (edge register), registered output same edge.
- **Charge progression:** `jump_dist` is non-zero for every CHARGE cycle and drops to 0 exactly one cycle after `fall` is seen. This nonzero→0 transition is the end-of-jump marker that `fsm` detects.
- **Saturation point:** `jump_dist` reaches `MAX_DIST` after `(MAX_DIST-MIN_DIST)*TICK_DIV` CHARGE cycles (112 with defaults).
- **`restart` pulse:** exactly `RESTART_CYCLES` cycles, starting the cycle after `rise` in DEAD_WAIT.
- **`charging` / `locked`:** are decoded from the registered state, so they are aligned with `jump_dist`.

## Test plan
- **Reset:** assert `rst_n=0` mid-CHARGE with `jump_dist=20` → all outputs 0 asynchronously; after release, state is IDLE.
- **Glitch rejection:** 3-cycle `btn` pulse with `DEBOUNCE_CYCLES=4` → `jump_dist` stays 0 and `charging` stays 0.
- **Normal charge:** 20 CHARGE cycles → `jump_dist` 4,4,5,5,…,13,13; next cycle 0; `last_dist=13`; `locked` high for exactly 40 cycles.
- **Saturation:** hold `btn` for 200 cycles → `jump_dist` holds at 60; after release `last_dist=60`.
- **Held through cooldown:** press again during COOLDOWN and keep holding → ignored; ARM until released; a fresh press then charges from 4.
- **Death and restart:** `dead=1` during CHARGE → `jump_dist=0` next cycle and `last_dist` unchanged. A press then gives `restart` high for exactly 2 cycles, and no charge starts until the button is released and pressed again.
